// File: rtl/auth_pkg.sv
// Shared command constants and controller state type for the authentication link.
// The receiver's command decode uses the same byte values.
package auth_pkg;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_ctrl_t;

  function automatic logic [7:0] cmd_byte(input logic is_stop);
    return is_stop ? CMD_STOP : CMD_GO;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmit core: start strobe loads a 10-bit frame and shifts it out LSB first.
// tx_done is high during the final clock of the stop bit.
module uart_tx_core #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;
  logic          r_busy;
  logic          w_bit_end;

  assign w_bit_end = r_busy && (r_baud == BW'(BAUD_DIV - 1));
  assign tx_done   = w_bit_end && (r_bit == 4'd9);
  assign TX        = r_shift[0];

  // Ones shift in behind the frame, so the line rests high without an output mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_busy  <= 1'b0;
    end else if (trmt) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, tx_data, 1'b0};
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud  <= '0;
        r_shift <= {1'b1, r_shift[9:1]};
        if (r_bit == 4'd9) begin
          r_bit  <= '0;
          r_busy <= 1'b0;
        end else begin
          r_bit <= r_bit + 4'd1;
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/auth_cmd_tx.sv
// Go/stop command transmitter: one-deep stop-priority request slot, frame controller,
// armed flag and optional 'g' heartbeat, driving a UART transmit core.
module auth_cmd_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV  = 2604,
  parameter int HB_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic go_req,
  input  logic stop_req,
  output logic TX,
  output logic tx_busy,
  output logic cmd_done,
  output logic armed
);

  localparam int HB_W = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;

  tx_ctrl_t      r_state;
  logic          r_slot_vld;
  logic          r_slot_stop;
  logic          r_is_stop;
  logic [7:0]    r_byte;
  logic          r_trmt;
  logic          r_tx_busy;
  logic          r_cmd_done;
  logic          r_armed;
  logic [HB_W-1:0] r_hb_cnt;

  logic w_consume;
  logic w_hb_run;
  logic w_hb_fire;
  logic w_core_done;

  assign w_consume = (r_state == IDLE) && r_slot_vld;
  assign w_hb_run  = (HB_CYCLES > 0) && r_armed && (r_state == IDLE) && !r_slot_vld
                     && !go_req && !stop_req;
  assign w_hb_fire = w_hb_run && (r_hb_cnt == HB_W'(HB_CYCLES - 1));

  // A go arriving on the edge that consumes the slot is kept for a later frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_vld  <= 1'b0;
      r_slot_stop <= 1'b0;
    end else if (stop_req) begin
      r_slot_vld  <= 1'b1;
      r_slot_stop <= 1'b1;
    end else if (go_req && (!r_slot_vld || w_consume)) begin
      r_slot_vld  <= 1'b1;
      r_slot_stop <= 1'b0;
    end else if (w_consume) begin
      r_slot_vld  <= 1'b0;
      r_slot_stop <= 1'b0;
    end else if (w_hb_fire) begin
      r_slot_vld  <= 1'b1;
      r_slot_stop <= 1'b0;
    end
  end

  // Heartbeat counter only advances through quiet armed idle time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hb_cnt <= '0;
    end else if (!w_hb_run || w_hb_fire) begin
      r_hb_cnt <= '0;
    end else begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte     <= '0;
      r_is_stop  <= 1'b0;
      r_trmt     <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_cmd_done <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_slot_vld) begin
            r_byte    <= cmd_byte(r_slot_stop);
            r_is_stop <= r_slot_stop;
            r_trmt    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_trmt    <= 1'b0;
          r_tx_busy <= 1'b1;
          r_state   <= SEND;
        end
        SEND: begin
          if (w_core_done) begin
            r_tx_busy  <= 1'b0;
            r_cmd_done <= 1'b1;
            r_armed    <= !r_is_stop;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_trmt    <= 1'b0;
          r_tx_busy <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .trmt   (r_trmt),
    .tx_data(r_byte),
    .TX     (TX),
    .tx_done(w_core_done)
  );

  assign tx_busy  = r_tx_busy;
  assign cmd_done = r_cmd_done;
  assign armed    = r_armed;

endmodule
